// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that frames two 32-bit sources as tagged packets onto one uart_tx.
// Optional feature macro UART_TX_SCHED_CHECKSUM_EN appends an XOR checksum byte to every packet.
module uart_tx_sched #(
  parameter logic [7:0]  HDR0     = 8'hA0,
  parameter logic [7:0]  HDR1     = 8'hB0,
  parameter int unsigned GAP_CLKS = 0
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [1:0]  i_Req,
  input  logic [31:0] i_Word0,
  input  logic [31:0] i_Word1,
  output logic [1:0]  o_Ack,
  output logic        o_Busy,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Done,
  input  logic        i_Tx_Active
);
  // state | meaning
  // IDLE  | waiting for a request while uart_tx is quiet
  // SEND  | one-cycle DV strobe for the current byte
  // WAIT  | waiting for uart_tx Done on the current byte
  // GAP   | inter-byte idle clocks
  // DONE  | one-cycle ack pulse to the packet owner

`ifdef UART_TX_SCHED_CHECKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif
  localparam int          SW       = 8 * NBYTES;
  localparam logic [2:0]  LAST_IDX = 3'(NBYTES - 1);
  localparam logic [15:0] GAP_LOAD = (GAP_CLKS > 0) ? 16'(GAP_CLKS - 1) : 16'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] sreg, sreg_nxt, pkt;
  logic [2:0]    idx, idx_nxt;
  logic          owner, owner_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic [15:0]   gap_cnt, gap_nxt;
  logic          grant, gnt_id, done_last;
  logic [31:0]   gnt_word;
  logic [7:0]    gnt_hdr;
  logic          dv_nxt, busy_nxt;
  logic [7:0]    byte_nxt;
  logic [1:0]    ack_nxt;

  // Tie goes to the requester not granted last; the uart_tx gate covers a byte left over from reset.
  always_comb begin
    grant    = (state == S_IDLE) && !i_Tx_Active && (|i_Req);
    gnt_id   = (&i_Req) ? ~last_gnt : i_Req[1];
    gnt_word = gnt_id ? i_Word1 : i_Word0;
    gnt_hdr  = gnt_id ? HDR1 : HDR0;
`ifdef UART_TX_SCHED_CHECKSUM_EN
    pkt      = {gnt_hdr, gnt_word,
                gnt_hdr ^ gnt_word[31:24] ^ gnt_word[23:16] ^ gnt_word[15:8] ^ gnt_word[7:0]};
`else
    pkt      = {gnt_hdr, gnt_word};
`endif
    done_last = (idx == LAST_IDX);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state     <= S_IDLE;
      sreg      <= '0;
      idx       <= 3'd0;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      gap_cnt   <= 16'd0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
      o_Ack     <= 2'b00;
      o_Busy    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      idx       <= idx_nxt;
      owner     <= owner_nxt;
      last_gnt  <= last_gnt_nxt;
      gap_cnt   <= gap_nxt;
      o_Tx_DV   <= dv_nxt;
      o_Tx_Byte <= byte_nxt;
      o_Ack     <= ack_nxt;
      o_Busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (grant) state_nxt = S_SEND;
      S_SEND: state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_Tx_Done) begin
          if (done_last)         state_nxt = S_DONE;
          else if (GAP_CLKS > 0) state_nxt = S_GAP;
          else                   state_nxt = S_SEND;
        end
      end
      S_GAP:  if (gap_cnt == 16'd0) state_nxt = S_SEND;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sreg_nxt     = sreg;
    idx_nxt      = idx;
    owner_nxt    = owner;
    last_gnt_nxt = last_gnt;
    gap_nxt      = gap_cnt;
    case (state)
      S_IDLE: begin
        if (grant) begin
          sreg_nxt     = pkt;
          idx_nxt      = 3'd0;
          owner_nxt    = gnt_id;
          last_gnt_nxt = gnt_id;
        end
      end
      S_WAIT: begin
        if (i_Tx_Done && !done_last) begin
          sreg_nxt = {sreg[SW-9:0], 8'h00};
          idx_nxt  = idx + 3'd1;
          gap_nxt  = GAP_LOAD;
        end
      end
      S_GAP: if (gap_cnt != 16'd0) gap_nxt = gap_cnt - 16'd1;
      default: ;
    endcase
  end

  // Outputs are computed from next-state values so they are registered yet aligned with the state.
  always_comb begin
    dv_nxt   = (state_nxt == S_SEND);
    byte_nxt = dv_nxt ? sreg_nxt[SW-1 -: 8] : o_Tx_Byte;
    ack_nxt  = (state_nxt == S_DONE) ? (owner_nxt ? 2'b10 : 2'b01) : 2'b00;
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: byte/ack scoreboard, vector table and timing sequences.
// Follows UART_TX_SCHED_CHECKSUM_EN to decide packet length.
`timescale 1ns/1ps
module tb_uart_tx_sched;
`ifdef UART_TX_SCHED_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic [1:0]  req    [2];
  logic [31:0] w0     [2];
  logic [31:0] w1     [2];
  logic        done   [2];
  logic        active [2];
  logic [1:0]  ack    [2];
  logic        busy   [2];
  logic        dv     [2];
  logic [7:0]  txb    [2];

  uart_tx_sched #(.GAP_CLKS(0)) u_dut0 (
    .i_Clock(clk), .i_Reset(rst[0]), .i_Req(req[0]), .i_Word0(w0[0]), .i_Word1(w1[0]),
    .o_Ack(ack[0]), .o_Busy(busy[0]), .o_Tx_DV(dv[0]), .o_Tx_Byte(txb[0]),
    .i_Tx_Done(done[0]), .i_Tx_Active(active[0])
  );

  uart_tx_sched #(.GAP_CLKS(3)) u_dut3 (
    .i_Clock(clk), .i_Reset(rst[1]), .i_Req(req[1]), .i_Word0(w0[1]), .i_Word1(w1[1]),
    .o_Ack(ack[1]), .o_Busy(busy[1]), .o_Tx_DV(dv[1]), .o_Tx_Byte(txb[1]),
    .i_Tx_Done(done[1]), .i_Tx_Active(active[1])
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  logic [1:0] ack_q[$];

  typedef struct {
    logic [1:0]  req;
    logic [31:0] word;
    logic [7:0]  hdr;
    logic [1:0]  ack;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input logic [31:0] w, input logic [1:0] a);
    logic [7:0] cks;
    cks = hdr;
    exp_q.push_back(hdr);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(w[31-8*i -: 8]);
      cks = cks ^ w[31-8*i -: 8];
    end
    if (NB == 6) exp_q.push_back(cks);
    ack_q.push_back(a);
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1; req[d] = 2'b00; done[d] = 1'b0; active[d] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dv",   64'(dv[d]),   64'd0);
    check("rst_byte", 64'(txb[d]),  64'd0);
    check("rst_ack",  64'(ack[d]),  64'd0);
    check("rst_busy", 64'(busy[d]), 64'd0);
    rst[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_dv(input int d, output bit ok);
    int n;
    n = 0;
    while (dv[d] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (dv[d] === 1'b1);
    if (!ok) begin
      n_total++;
      $display("FAIL dv_timeout: got no DV within %0d cycles, required a DV", n);
    end
  endtask

  task automatic cmp_byte(input int d);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL byte_extra: got %0h, required no byte", txb[d]);
    end else begin
      e = exp_q.pop_front();
      check("tx_byte", 64'(txb[d]), 64'(e));
    end
  endtask

  task automatic take_byte(input int d);
    bit ok;
    wait_dv(d, ok);
    if (ok) begin
      cmp_byte(d);
      @(negedge clk);
      check("dv_one_cycle", 64'(dv[d]), 64'd0);
    end
  endtask

  task automatic ret_done(input int d, input int dly);
    repeat (dly) @(negedge clk);
    done[d] = 1'b1;
    @(negedge clk);
    done[d] = 1'b0;
  endtask

  task automatic serve_pkt(input int d, input bit drop);
    logic [1:0] ea;
    for (int i = 0; i < NB; i++) begin
      take_byte(d);
      ret_done(d, 85);
    end
    ea = (ack_q.size() != 0) ? ack_q.pop_front() : 2'b00;
    check("ack_pulse", 64'(ack[d]), 64'(ea));
    if (drop) req[d] = req[d] & ~ea;
    @(negedge clk);
    check("ack_width", 64'(ack[d]), 64'd0);
    check("idle_after_ack", 64'(busy[d]), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int bad;
    vec_t v;
    vecs[0] = '{req: 2'b01, word: 32'hDEADBEEF, hdr: 8'hA0, ack: 2'b01};
    vecs[1] = '{req: 2'b10, word: 32'hCAFEF00D, hdr: 8'hB0, ack: 2'b10};
    vecs[2] = '{req: 2'b01, word: 32'h00000000, hdr: 8'hA0, ack: 2'b01};
    vecs[3] = '{req: 2'b10, word: 32'hFFFFFFFF, hdr: 8'hB0, ack: 2'b10};
    vecs[4] = '{req: 2'b10, word: 32'h13579BDF, hdr: 8'hB0, ack: 2'b10};
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 2'b00; w0[d] = '0; w1[d] = '0; done[d] = 1'b0; active[d] = 1'b0;
    end

    do_reset(0);
    do_reset(1);

    // single-request vectors; words are scrambled after grant to prove they were latched
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      w0[0] = v.req[0] ? v.word : ~v.word;
      w1[0] = v.req[1] ? v.word : ~v.word;
      req[0] = v.req;
      push_pkt(v.hdr, v.word, v.ack);
      @(negedge clk);
      check("grant_lat", 64'(dv[0]), 64'd1);
      w0[0] = 32'h5A5A5A5A;
      w1[0] = 32'hA5A5A5A5;
      serve_pkt(0, 1'b1);
    end

    // tie from reset: requester 0 first, then 1
    do_reset(0);
    w0[0] = 32'h11223344; w1[0] = 32'h55667788;
    push_pkt(8'hA0, 32'h11223344, 2'b01);
    push_pkt(8'hB0, 32'h55667788, 2'b10);
    req[0] = 2'b11;
    serve_pkt(0, 1'b1);
    serve_pkt(0, 1'b1);

    // fairness: requester 0 held, requester 1 raised mid-packet
    do_reset(0);
    w0[0] = 32'hAAAA0001; w1[0] = 32'hBBBB0002;
    push_pkt(8'hA0, 32'hAAAA0001, 2'b01);
    req[0] = 2'b01;
    @(negedge clk);
    check("fair_grant_lat", 64'(dv[0]), 64'd1);
    req[0] = 2'b11;
    w0[0] = 32'hCCCC0003;
    push_pkt(8'hB0, 32'hBBBB0002, 2'b10);
    push_pkt(8'hA0, 32'hCCCC0003, 2'b01);
    serve_pkt(0, 1'b0);
    serve_pkt(0, 1'b1);
    serve_pkt(0, 1'b1);

    // spurious Done in IDLE and SEND, then inter-byte gap of 3 clocks
    do_reset(1);
    done[1] = 1'b1;
    @(negedge clk);
    done[1] = 1'b0;
    @(negedge clk);
    check("spur_idle_dv", 64'(dv[1]), 64'd0);
    check("spur_idle_busy", 64'(busy[1]), 64'd0);
    w0[1] = 32'h01020304;
    push_pkt(8'hA0, 32'h01020304, 2'b01);
    req[1] = 2'b01;
    @(negedge clk);
    check("gap_grant_lat", 64'(dv[1]), 64'd1);
    cmp_byte(1);
    done[1] = 1'b1;
    @(negedge clk);
    done[1] = 1'b0;
    check("spur_send_dv", 64'(dv[1]), 64'd0);
    check("spur_send_busy", 64'(busy[1]), 64'd1);
    for (int i = 1; i < NB; i++) begin
      repeat (5) @(negedge clk);
      check("wait_no_dv", 64'(dv[1]), 64'd0);
      done[1] = 1'b1;
      @(negedge clk);
      done[1] = 1'b0;
      cnt = 1;
      while (dv[1] !== 1'b1 && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      check("gap_latency", 64'(cnt), 64'd4);
      cmp_byte(1);
      @(negedge clk);
      check("gap_dv_one_cycle", 64'(dv[1]), 64'd0);
    end
    repeat (5) @(negedge clk);
    done[1] = 1'b1;
    @(negedge clk);
    done[1] = 1'b0;
    check("gap_ack", 64'(ack[1]), 64'(ack_q.pop_front()));
    req[1] = 2'b00;
    @(negedge clk);
    check("gap_ack_width", 64'(ack[1]), 64'd0);
    check("gap_idle", 64'(busy[1]), 64'd0);

    // reset while the third byte is strobed, with uart_tx still active afterwards
    do_reset(0);
    w0[0] = 32'hDEADBEEF;
    push_pkt(8'hA0, 32'hDEADBEEF, 2'b01);
    req[0] = 2'b01;
    take_byte(0);
    ret_done(0, 85);
    take_byte(0);
    ret_done(0, 85);
    check("pre_rst_dv", 64'(dv[0]), 64'd1);
    active[0] = 1'b1;
    rst[0] = 1'b1;
    done[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    done[0] = 1'b0;
    check("midrst_dv", 64'(dv[0]), 64'd0);
    check("midrst_ack", 64'(ack[0]), 64'd0);
    check("midrst_busy", 64'(busy[0]), 64'd0);
    exp_q.delete();
    ack_q.delete();
    push_pkt(8'hA0, 32'hDEADBEEF, 2'b01);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (dv[0] !== 1'b0 || busy[0] !== 1'b0 || ack[0] !== 2'b00) bad++;
    end
    check("active_gate", 64'(bad), 64'd0);
    active[0] = 1'b0;
    @(negedge clk);
    check("regrant_lat", 64'(dv[0]), 64'd1);
    serve_pkt(0, 1'b1);

    check("queues_empty", 64'(exp_q.size() + ack_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester scheduler that shares the single `uart_tx` instance between on-chip message sources, such as the nonce-result path and the status heartbeat. Each requester presents a 32-bit word. The block arbitrates round-robin and frames the word as a tagged packet: header byte, then four data bytes MSB first. It drives the `uart_tx` DV/byte handshake and paces on `o_Tx_Done`. It sits between the miner core and `uart_tx` in the 10 MHz clock domain.

## Interface
- `HDR0`, default 8'hA0: header byte for requester 0 packets.
- `HDR1`, default 8'hB0: header byte for requester 1 packets.
- `GAP_CLKS`, default 0: idle clocks inserted after each byte's Done before the next DV (0 to 65535).

- `i_Clock`  in  1  system clock, 10 MHz domain.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Req`  in  2  level request per requester; word must be valid while high.
- `i_Word0`  in  32  requester 0 payload.
- `i_Word1`  in  32  requester 1 payload.
- `o_Ack`  out  2  one-cycle pulse on the served bit when its packet has fully transmitted.
- `o_Busy`  out  1  high in every state except IDLE.
- `o_Tx_DV`  out  1  one-cycle byte-valid strobe to `uart_tx` `i_Tx_DV`.
- `o_Tx_Byte`  out  8  byte to `uart_tx` `i_Tx_Byte`; valid while `o_Tx_DV` is high.
- `i_Tx_Done`  in  1  from `uart_tx` `o_Tx_Done`.
- `i_Tx_Active`  in  1  from `uart_tx` `o_Tx_Active`.

## Operation
- States: IDLE, SEND, WAIT, GAP, DONE.
- IDLE:
  - Grant only when `i_Tx_Active`=0 and at least one `i_Req` bit is high.
  - If both requesters are asking, grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - On grant: latch the granted word and its header into a 40-bit shift register, clear the byte index, record the owner, update the pointer, and go to SEND.
- SEND: assert `o_Tx_DV`=1 for exactly one cycle with `o_Tx_Byte` set to the current byte, then go to WAIT.
- WAIT:
  - On `i_Tx_Done`=1 with the last byte sent, go to DONE.
  - On `i_Tx_Done`=1 otherwise, advance the index and go to GAP if `GAP_CLKS`>0, else to SEND.
- GAP: count `GAP_CLKS` cycles, then go to SEND.
- DONE: pulse `o_Ack[owner]` for one cycle, then go to IDLE.
- Byte order: header, word[31:24], word[23:16], word[15:8], word[7:0].
- Input changes after the grant do not affect an in-flight packet.
- `i_Tx_Done` outside WAIT is ignored.
- `i_Req` bits raised mid-packet are held off until IDLE. A request is never dropped as long as it stays high.
- Requester protocol: deassert `i_Req` on the clock edge after observing `o_Ack`. The request is not resampled until the following IDLE cycle. A requester that keeps its request high is re-queued under round-robin.

## Timing
- All outputs are registered.
- Reset values: `o_Tx_DV`=0, `o_Tx_Byte`=8'h00, `o_Ack`=2'b00, `o_Busy`=0, state IDLE, GAP counter 0.
- Grant latency: `i_Req` sampled high in IDLE at edge N gives `o_Tx_DV`=1 during cycle N+1.
- Byte-to-byte latency: `i_Tx_Done` sampled at edge M gives the next `o_Tx_DV` during cycle M+1+`GAP_CLKS`.
- Ack timing: Done on the last byte at edge M gives `o_Ack` high during cycle M+1 and IDLE during cycle M+2.
- `o_Tx_Byte` holds its last value between strobes.
- Reset asserted mid-packet:
  - Takes effect on the next edge: IDLE, no `o_Ack`, `o_Tx_DV` forced to 0.
  - The partially sent packet is abandoned.
  - A byte already shifting in `uart_tx` completes on its own. The `i_Tx_Active` gate in IDLE prevents overlap with it.
- Simultaneous `i_Tx_Done` and `i_Reset`: reset wins.

## Configuration
- `UART_TX_SCHED_CHECKSUM_EN` defined:
  - A sixth byte is appended: the XOR of the header and the four data bytes.
  - `o_Ack` follows the sixth byte's Done.
- Macro not defined: five-byte packets, and no checksum logic is compiled.

## Test plan
- Single request: `i_Req`=01, `i_Word0`=32'hDEADBEEF, Done returned 87 clocks after each DV.
  - Without the macro: bytes A0 DE AD BE EF, then `o_Ack`=01 one cycle after the fifth Done.
  - With the macro: the sixth byte is 8'h82.
- Tie: `i_Req`=11 from reset with words 11223344 and 55667788, both held until acked.
  - Required order: A0 11 22 33 44, then B0 55 66 77 88.
  - Acks 01 then 10, each one cycle wide.
- Fairness: requester 0 keeps `i_Req` high continuously and requester 1 requests once.
  - Required: packets alternate 0, 1, 0.
  - Requester 1 waits at most one packet.
- Spurious Done and gap, with `GAP_CLKS`=3:
  - Pulse `i_Tx_Done` in IDLE and in SEND: no state change and no extra DV.
  - Measure 4 cycles from each WAIT Done to the next DV.
- Reset after the second byte:
  - Required: `o_Tx_DV`=0 the next cycle, no `o_Ack`.
  - With `i_Tx_Active`=1 held for 50 clocks, a fresh `i_Req`=01 is not granted until `i_Tx_Active`=0.
  - The next packet then restarts from the header.
